// File: rtl/lock_pkg.sv
// Shared types and elaboration-time helpers for the canal gate array controller.
package lock_pkg;

  typedef enum logic [1:0] {
    G_CLOSED  = 2'd0,
    G_OPENING = 2'd1,
    G_OPEN    = 2'd2,
    G_CLOSING = 2'd3
  } gate_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_motion.sv
// One canal gate: CLOSED/OPENING/OPEN/CLOSING state register with a shared travel/hold timer.
module gate_motion
  import lock_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned MIN_OPEN      = 4,
  parameter int unsigned TW            = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grant,
  input  logic        level_ok,
  input  logic        req,
  output gate_state_t state,
  output logic        open,
  output logic        closed,
  output logic        moving
);

  localparam logic [TW-1:0] TRAV_MAX = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] OPEN_MAX = TW'(MIN_OPEN - 1);

  gate_state_t   r_state, w_state_nx;
  logic [TW-1:0] r_timer, w_timer_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= G_CLOSED;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    unique case (r_state)
      G_CLOSED: begin
        if (grant) begin
          w_state_nx = G_OPENING;
          w_timer_nx = '0;
        end
      end
      G_OPENING: begin
        // Abort keeps the timer so the close mirrors the travel already done.
        if (!level_ok) begin
          w_state_nx = G_CLOSING;
        end else if (r_timer == TRAV_MAX) begin
          w_state_nx = G_OPEN;
          w_timer_nx = '0;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      G_OPEN: begin
        if (r_timer == OPEN_MAX) begin
          if (!req || !level_ok) begin
            w_state_nx = G_CLOSING;
            w_timer_nx = TRAV_MAX;
          end
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      G_CLOSING: begin
        if (r_timer == '0) begin
          w_state_nx = G_CLOSED;
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_nx = G_CLOSED;
        w_timer_nx = '0;
      end
    endcase
  end

  assign state  = r_state;
  assign open   = (r_state == G_OPEN);
  assign closed = (r_state == G_CLOSED);
  assign moving = (r_state == G_OPENING) || (r_state == G_CLOSING);

endmodule

// File: rtl/gate_array_ctrl.sv
// Interlocked canal gate array: round-robin grant to at most one gate, only while all gates are closed.
module gate_array_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned NUM_GATES     = 2,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned MIN_OPEN      = 4,
  localparam int unsigned GW           = clog2_min1(NUM_GATES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] req,
  input  logic [NUM_GATES-1:0] level_ok,
  output logic [NUM_GATES-1:0] open,
  output logic [NUM_GATES-1:0] closed,
  output logic [NUM_GATES-1:0] moving,
  output logic [GW-1:0]        active_id,
  output logic                 busy
);

  localparam int unsigned TW = clog2_min1(max_u(TRAVEL_CYCLES, MIN_OPEN)) + 1;

  gate_state_t          w_state [NUM_GATES];
  logic [NUM_GATES-1:0] w_active;
  logic [NUM_GATES-1:0] w_cand;
  logic [NUM_GATES-1:0] w_grant;
  logic                 w_all_closed;
  logic                 w_found;
  logic [GW-1:0]        w_win;
  logic [GW-1:0]        w_rr_nx;
  logic [GW:0]          w_idx;
  logic [GW-1:0]        w_aid;
  logic [GW-1:0]        r_rr;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_motion #(
      .TRAVEL_CYCLES (TRAVEL_CYCLES),
      .MIN_OPEN      (MIN_OPEN),
      .TW            (TW)
    ) u_gate (
      .clk      (clk),
      .reset    (reset),
      .grant    (w_grant[g]),
      .level_ok (level_ok[g]),
      .req      (req[g]),
      .state    (w_state[g]),
      .open     (open[g]),
      .closed   (closed[g]),
      .moving   (moving[g])
    );
    assign w_active[g] = (w_state[g] != G_CLOSED);
  end

  assign w_cand       = req & level_ok;
  assign w_all_closed = ~|w_active;

  // Scan candidates starting at the rr pointer, wrapping at NUM_GATES.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_GATES; k++) begin
      w_idx = {1'b0, r_rr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(NUM_GATES)) w_idx = w_idx - (GW+1)'(NUM_GATES);
      if (!w_found && w_cand[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[GW-1:0];
      end
    end
    if (w_all_closed && w_found) w_grant[w_win] = 1'b1;
  end

  assign w_rr_nx = (w_win == GW'(NUM_GATES - 1)) ? '0 : w_win + GW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr <= '0;
    end else if (|w_grant) begin
      r_rr <= w_rr_nx;
    end
  end

  always_comb begin
    w_aid = '0;
    for (int unsigned i = 0; i < NUM_GATES; i++) begin
      if (w_active[i]) w_aid = GW'(i);
    end
  end

  assign active_id = w_aid;
  assign busy      = ~w_all_closed;

endmodule

// File: tb/tb_gate_array_ctrl.sv
// Scoreboard bench for gate_array_ctrl: phase-level reference model feeds an expectation queue drained by a monitor.
module tb_gate_array_ctrl;

  localparam int N = 2;
  localparam int T = 4;
  localparam int M = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] level_ok;
  logic [N-1:0] open;
  logic [N-1:0] closed;
  logic [N-1:0] moving;
  logic [0:0]   active_id;
  logic         busy;

  always #5 clk = ~clk;

  gate_array_ctrl #(
    .NUM_GATES     (N),
    .TRAVEL_CYCLES (T),
    .MIN_OPEN      (M)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .level_ok  (level_ok),
    .open      (open),
    .closed    (closed),
    .moving    (moving),
    .active_id (active_id),
    .busy      (busy)
  );

  typedef logic [7:0] obs_t;  // {open, closed, moving, active_id, busy}

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which gate is out of CLOSED, which phase it is in, and how long it has been there.
  int m_act;   // -1 when every gate is closed
  int m_ph;    // 0 opening, 1 open, 2 closing
  int m_n;     // cycles spent in current phase
  int m_clen;  // length of the current closing phase
  int m_rr;

  task automatic model_reset();
    m_act = -1; m_ph = 0; m_n = 0; m_clen = 0; m_rr = 0;
  endtask

  task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] lv);
    int g;
    if (m_act < 0) begin
      for (int k = 0; k < N; k++) begin
        g = (m_rr + k) % N;
        if (m_act < 0 && rq[g] && lv[g]) begin
          m_act = g; m_ph = 0; m_n = 0; m_rr = (g + 1) % N;
        end
      end
    end else begin
      case (m_ph)
        0: begin
          if (!lv[m_act]) begin
            m_ph = 2; m_clen = m_n + 1; m_n = 0;
          end else if (m_n + 1 == T) begin
            m_ph = 1; m_n = 0;
          end else m_n++;
        end
        1: begin
          if (m_n >= M - 1 && (!rq[m_act] || !lv[m_act])) begin
            m_ph = 2; m_clen = T; m_n = 0;
          end else m_n++;
        end
        default: begin
          m_n++;
          if (m_n == m_clen) m_act = -1;
        end
      endcase
    end
  endtask

  function automatic obs_t model_out();
    logic [N-1:0] o, c, mv;
    logic [0:0]   aid;
    o = '0; c = '1; mv = '0; aid = '0;
    if (m_act >= 0) begin
      c[m_act] = 1'b0;
      if (m_ph == 1) o[m_act] = 1'b1;
      else           mv[m_act] = 1'b1;
      aid = 1'(m_act);
    end
    return {o, c, mv, aid, (m_act >= 0)};
  endfunction

  function automatic obs_t dut_out();
    return {open, closed, moving, active_id, busy};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b (open,closed,moving,id,busy)", name, $time, got, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if ($countones(~closed) > 1) begin
        errors++;
        $display("FAIL interlock at %0t: closed=%b, more than one gate not closed", $time, closed);
      end
      if (q.size() > 0) check("outputs", dut_out(), q.pop_front());
    end
  end

  task automatic step(input logic rst_v, input logic [N-1:0] rq, input logic [N-1:0] lv);
    @(posedge clk);
    #2;
    reset = rst_v; req = rq; level_ok = lv;
    if (!rst_v) model_reset();
    else        model_step(rq, lv);
    q.push_back(model_out());
  endtask

  task automatic hold(input logic [N-1:0] rq, input logic [N-1:0] lv, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, rq, lv);
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    q.delete();
    model_reset();
    check("async_reset", dut_out(), model_out());
    step(1'b0, req, level_ok);
  endtask

  initial begin
    logic [N-1:0] rr_req;
    logic [N-1:0] rr_lv;
    reset = 1'b1; req = '0; level_ok = '0;
    model_reset();
    #1 reset = 1'b0;
    #2 check("reset_state", dut_out(), model_out());
    step(1'b0, 2'b00, 2'b00);

    // Open gate0, drop req after one OPEN cycle.
    hold(2'b01, 2'b01, 6);
    hold(2'b00, 2'b01, 10);

    // Simultaneous requests from reset: gate0 first, then gate1 via rr.
    step(1'b0, 2'b00, 2'b00);
    hold(2'b11, 2'b11, 8);
    hold(2'b10, 2'b11, 22);
    hold(2'b00, 2'b11, 10);

    // Interlock: gate1 requests while gate0 is open.
    hold(2'b01, 2'b11, 7);
    hold(2'b11, 2'b11, 3);
    hold(2'b10, 2'b11, 16);
    hold(2'b00, 2'b11, 10);

    // Abort in the second OPENING cycle.
    hold(2'b01, 2'b01, 2);
    hold(2'b01, 2'b00, 1);
    hold(2'b00, 2'b00, 8);

    // Level loss in the first OPEN cycle still honours the minimum open time.
    step(1'b0, 2'b00, 2'b00);
    hold(2'b01, 2'b01, 5);
    hold(2'b01, 2'b00, 12);

    // Async reset while gate0 is CLOSING.
    hold(2'b01, 2'b01, 6);
    hold(2'b00, 2'b01, 3);
    async_reset_pulse();
    hold(2'b00, 2'b00, 4);

    // Randomised traffic with occasional level loss.
    rr_req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) rr_req[b] = ~rr_req[b];
        rr_lv[b] = ($urandom_range(0, 11) != 0);
      end
      hold(rr_req, rr_lv, 1);
    end

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
